// File: rtl/stoch_decode_pkg.sv
// Shared types and helpers for the stochastic-to-binary decoder matrix.
package stoch_decode_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} decode_state_t;

  // Element counters need one extra bit so an all-ones window reaches 2^W without wrapping.
  function automatic int unsigned count_width(input int unsigned window_log2);
    return window_log2 + 1;
  endfunction

endpackage

// File: rtl/stoch_decode.sv
// Single-element ones counter with a result register loaded at window end.
// Optional build macro STOCH_DECODE_SAT_EN clamps the loaded result to 2^WINDOW_LOG2-1.
module stoch_decode
  import stoch_decode_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 a,
  input  logic                 load,
  output logic [WINDOW_LOG2:0] count
);

  localparam int unsigned CW = count_width(WINDOW_LOG2);

  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] sum_c;
  logic [CW-1:0] load_val_c;

`ifdef STOCH_DECODE_SAT_EN
  localparam logic [CW-1:0] SAT_MAX = {1'b0, {WINDOW_LOG2{1'b1}}};
`endif

  // The final sample is folded into the loaded value on the last window cycle.
  always_comb begin
    sum_c = acc_q + CW'(a);
`ifdef STOCH_DECODE_SAT_EN
    load_val_c = sum_c[CW-1] ? SAT_MAX : sum_c;
`else
    load_val_c = sum_c;
`endif
    acc_d   = acc_q;
    count_d = count_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum_c;
    end
    if (load) begin
      count_d = load_val_c;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stoch_decode_mat.sv
// Element-wise stochastic bitstream decoder: one shared window FSM drives a grid of counters.
// Build macro STOCH_DECODE_SAT_EN selects saturating Y (handled per element in stoch_decode).
module stoch_decode_mat
  import stoch_decode_pkg::*;
#(
  parameter int unsigned NUM_ROWS    = 2,
  parameter int unsigned NUM_COLS    = 2,
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic                                         CLK,
  input  logic                                         nRST,
  input  logic                                         start,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]            A,
  output logic                                         busy,
  output logic                                         valid,
  input  logic                                         ready,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2:0] Y
);

  decode_state_t state_q, state_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;
  logic clr_c, en_c, load_c;

  // Window sequencing; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    clr_c   = 1'b0;
    en_c    = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr_c   = 1'b1;
          win_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        en_c  = 1'b1;
        win_d = win_q + WINDOW_LOG2'(1);
        if (win_q == '1) begin
          load_c  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == ACCUM);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      win_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;

  for (genvar r = 0; r < int'(NUM_ROWS); r++) begin : g_row
    for (genvar c = 0; c < int'(NUM_COLS); c++) begin : g_col
      stoch_decode #(
        .WINDOW_LOG2(WINDOW_LOG2)
      ) u_elem (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (clr_c),
        .en    (en_c),
        .a     (A[r][c]),
        .load  (load_c),
        .count (Y[r][c])
      );
    end
  end

endmodule

// File: doc/stoch_decode_mat.md
Name: stoch_decode_mat

Overview:
- Element-wise stochastic-to-binary decoder matrix; sits directly downstream of stoch_div_mat and the other stochastic matrix ops.
- Counts ones on each element's bitstream over a window of 2^WINDOW_LOG2 cycles.
- Presents the per-element counts as unsigned fixed-point estimates (count / 2^WINDOW_LOG2) with a valid/ready output handshake.
- All elements share one window FSM, so results are sample-aligned.

Parameters:
- NUM_ROWS, 2, matrix rows.
- NUM_COLS, 2, matrix columns.
- WINDOW_LOG2, 8, window length is 2^WINDOW_LOG2 cycles; legal range 1..16.

Ports:
- CLK  input  1  clock; all state on rising edge.
- nRST  input  1  reset; asynchronous assert, active-low.
- start  input  1  request a new decode window; honoured only in IDLE.
- A  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  element bitstreams, one bit per element per cycle.
- busy  output  1  high while in ACCUM.
- valid  output  1  result available in Y.
- ready  input  1  consumer accepts Y when valid&ready.
- Y  output  [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2:0]  per-element ones-count, Q1.WINDOW_LOG2 unsigned.

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE, window counter=0, all element counters=0, Y=0, valid=0, busy=0.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 clears all element counters and the window counter; next state ACCUM.
  - start=0 stays in IDLE.
- ACCUM:
  - Each cycle, every element counter increments by A[i][j].
  - The window counter (WINDOW_LOG2 bits) increments.
  - On the cycle the window counter equals 2^WINDOW_LOG2-1, that cycle's sample is included and the final counts (counter+A[i][j]) load into Y.
  - valid is set and the next state is HOLD.
  - busy=1 throughout ACCUM.
  - start is ignored.
- HOLD:
  - Y is stable and valid=1.
  - On valid&ready, valid is cleared and the next state is IDLE.
  - start is ignored in HOLD, including on the handshake cycle; a new start is honoured from the following cycle.
  - Y keeps its value after the handshake until the next window completes.
- Latency: start high at edge 0 → samples taken at edges 1..2^WINDOW_LOG2 → valid high after edge 2^WINDOW_LOG2.
  - Minimum start-to-start period is 2^WINDOW_LOG2+2 cycles with ready tied high.
- Width rules:
  - Element counters are WINDOW_LOG2+1 bits, so an all-ones stream yields exactly 2^WINDOW_LOG2 with no wrap.
  - The window counter wraps to 0 naturally at window end.
- Reset mid-ACCUM or mid-HOLD: the partial result is discarded and all outputs return to their reset values immediately.
- X on A while in IDLE or HOLD has no effect.

Optional Feature:
- Macro STOCH_DECODE_SAT_EN.
- Defined: each loaded Y element is clamped to 2^WINDOW_LOG2-1, so the MSB of every element is always 0 and downstream may treat Y as a pure Q0.WINDOW_LOG2 fraction.
- Not defined: the full count 0..2^WINDOW_LOG2 is presented unmodified.
- Port widths are identical in both builds.

Decomposition:
- Package stoch_decode_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, HOLD} decode_state_t;
  - function count_width(window_log2) returning window_log2+1.
- Sub-module stoch_decode:
  - Single-element counter with inputs CLK, nRST, clr, en, a, load.
  - Output count [WINDOW_LOG2:0]; implements the saturation macro.
  - Instantiated per element in row/col generate loops.
- The FSM and window counter live once in stoch_decode_mat.

Test Plan:
- WINDOW_LOG2=4, 2x2, A tied all ones, start pulse, ready=1 → valid after exactly 16 sample cycles; every Y=16 (15 with STOCH_DECODE_SAT_EN); busy high 16 cycles.
- A[0][0] alternating 1010…, A[0][1]=0, A[1][0]=1, A[1][1] one-hot every 4th cycle, WINDOW_LOG2=4 → Y={8,0,16,4} (16 saturates to 15 when the macro is defined).
- Backpressure: ready=0 for 10 cycles after valid, A toggling meanwhile → Y and valid stable; handshake on ready=1; next cycle valid=0, state IDLE.
- start pulses during ACCUM and on the HOLD handshake cycle → ignored, no restart, result unchanged; a start on the following cycle begins a fresh window from zero.
- nRST asserted asynchronously mid-ACCUM (between clock edges) → busy, valid, Y go to 0 without waiting for CLK; after release a new start produces a correct full-window count.
- Randomised streams with probability p per element over 256-cycle windows (WINDOW_LOG2=8) → Y matches a scoreboard popcount exactly.
